mux_4_to_1_scanner: RTL and testbench

- Collector counterpart to the 1-to-4 LED demux: gathers four 1-bit inputs (board switches or other single-bit sources) onto one output channel.
- A free-running tick counter sets the sample rate. Each tick samples one channel.
- Channel selection is either auto round-robin or manual via two select inputs.
- Reports the sampled value, the channel index, a valid strobe and a per-channel change flag. Sits between raw board inputs and downstream LED/LFSR logic.

---
 rtl/mux_4_to_1_scanner_if.sv | 26 ++
 rtl/mux_4_to_1_scanner.sv | 95 +++++++++
 tb/tb_mux_4_to_1_scanner.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_4_to_1_scanner_if.sv
// Bus bundle for the 4-to-1 scanner: four raw data lines plus mode/select in,
// sampled value, channel index, strobes and per-channel snapshot out.
interface mux_4_to_1_scanner_if;
    logic       i_Data0;
    logic       i_Data1;
    logic       i_Data2;
    logic       i_Data3;
    logic       i_Auto;
    logic       i_Sel0;
    logic       i_Sel1;
    logic       o_Data;
    logic [1:0] o_Sel;
    logic       o_Sample_Valid;
    logic       o_Change;
    logic [3:0] o_Snapshot;

    modport master (
        output i_Data0, i_Data1, i_Data2, i_Data3, i_Auto, i_Sel0, i_Sel1,
        input  o_Data, o_Sel, o_Sample_Valid, o_Change, o_Snapshot
    );

    modport slave (
        input  i_Data0, i_Data1, i_Data2, i_Data3, i_Auto, i_Sel0, i_Sel1,
        output o_Data, o_Sel, o_Sample_Valid, o_Change, o_Snapshot
    );
endinterface

// File: rtl/mux_4_to_1_scanner.sv
// Samples one of four asynchronous 1-bit inputs per tick, either round-robin
// or by manual select, and reports value, channel, strobes and a snapshot.
module mux_4_to_1_scanner #(
    parameter int unsigned SCAN_LIMIT  = 4194303,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                 i_Clk,
    input logic                 i_Rst_L,
    mux_4_to_1_scanner_if.slave bus
);
    localparam logic [23:0] LIMIT = 24'(SCAN_LIMIT);

    // Bit order: {sel1, sel0, auto, data3, data2, data1, data0}
    logic [6:0]                  raw;
    logic [SYNC_STAGES-1:0][6:0] sync_q;
    logic [6:0]                  synced;
    logic [3:0]                  data_sync;
    logic                        auto_sync;
    logic [1:0]                  man_sel;

    logic [23:0] count;
    logic        tick;
    logic [1:0]  nsel;

    logic        data_q;
    logic [1:0]  sel_q;
    logic        valid_q;
    logic        change_q;
    logic [3:0]  snap_q;

    assign raw = {bus.i_Sel1, bus.i_Sel0, bus.i_Auto,
                  bus.i_Data3, bus.i_Data2, bus.i_Data1, bus.i_Data0};

    assign synced    = sync_q[SYNC_STAGES-1];
    assign data_sync = synced[3:0];
    assign auto_sync = synced[4];
    assign man_sel   = synced[6:5];

    // NOTE: reset is sampled on the clock edge only; synchronisers are cleared
    // too so stale pin levels cannot leak into the first samples after reset.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking so every stage shifts from its pre-edge value.
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign tick = (count == LIMIT);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 24'd1;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves nsel unassigned (no latch).
        nsel = man_sel;
        if (auto_sync) begin
            nsel = sel_q + 2'd1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            data_q   <= 1'b0;
            sel_q    <= 2'd3;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
            snap_q   <= '0;
        end else begin
            valid_q  <= tick;
            change_q <= 1'b0;
            if (tick) begin
                sel_q        <= nsel;
                data_q       <= data_sync[nsel];
                snap_q[nsel] <= data_sync[nsel];
                // Compared against the snapshot bit as it stood before this sample
                change_q     <= data_sync[nsel] ^ snap_q[nsel];
            end
        end
    end

    assign bus.o_Data         = data_q;
    assign bus.o_Sel          = sel_q;
    assign bus.o_Sample_Valid = valid_q;
    assign bus.o_Change       = change_q;
    assign bus.o_Snapshot     = snap_q;
endmodule

// File: tb/tb_mux_4_to_1_scanner.sv
// Bench for mux_4_to_1_scanner: directed test-plan steps plus random stimulus,
// with a per-cycle reference model covering a SCAN_LIMIT=3 and a SCAN_LIMIT=0 build.
module tb_mux_4_to_1_scanner;
    localparam int SYNC = 2;
    localparam int LIM0 = 3;
    localparam int LIM1 = 0;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mux_4_to_1_scanner_if bus0 ();
    mux_4_to_1_scanner_if bus1 ();

    assign bus1.i_Data0 = bus0.i_Data0;
    assign bus1.i_Data1 = bus0.i_Data1;
    assign bus1.i_Data2 = bus0.i_Data2;
    assign bus1.i_Data3 = bus0.i_Data3;
    assign bus1.i_Auto  = bus0.i_Auto;
    assign bus1.i_Sel0  = bus0.i_Sel0;
    assign bus1.i_Sel1  = bus0.i_Sel1;

    mux_4_to_1_scanner #(.SCAN_LIMIT(LIM0), .SYNC_STAGES(SYNC)) dut0 (
        .i_Clk(clk), .i_Rst_L(rst_n), .bus(bus0.slave));
    mux_4_to_1_scanner #(.SCAN_LIMIT(LIM1), .SYNC_STAGES(SYNC)) dut1 (
        .i_Clk(clk), .i_Rst_L(rst_n), .bus(bus1.slave));

    // Reference model: a queue stands in for the synchroniser delay, and a tick
    // falls on every (L+1)-th cycle counted from the last reset edge.
    logic [6:0] pipe_q[$];
    int         m_cyc   [2];
    int         m_lim   [2];
    logic [1:0] m_sel   [2];
    logic       m_data  [2];
    logic       m_valid [2];
    logic       m_change[2];
    logic [3:0] m_snap  [2];
    logic [6:0] m_synced;
    logic [1:0] m_ns;

    initial begin
        m_lim[0] = LIM0;
        m_lim[1] = LIM1;
        for (int i = 0; i < SYNC; i++) pipe_q.push_back(7'd0);
    end

    always @(posedge clk) begin
        m_synced = pipe_q[0];
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_cyc[d] = 0; m_sel[d] = 2'd3; m_data[d] = 1'b0;
                m_valid[d] = 1'b0; m_change[d] = 1'b0; m_snap[d] = 4'd0;
            end else begin
                m_valid[d]  = 1'b0;
                m_change[d] = 1'b0;
                if (m_cyc[d] % (m_lim[d] + 1) == m_lim[d]) begin
                    m_ns = m_synced[4] ? 2'((int'(m_sel[d]) + 1) % 4) : m_synced[6:5];
                    m_valid[d]      = 1'b1;
                    m_sel[d]        = m_ns;
                    m_data[d]       = m_synced[m_ns];
                    m_change[d]     = m_synced[m_ns] != m_snap[d][m_ns];
                    m_snap[d][m_ns] = m_synced[m_ns];
                end
                m_cyc[d]++;
            end
        end
        if (!rst_n) begin
            pipe_q.delete();
            for (int i = 0; i < SYNC; i++) pipe_q.push_back(7'd0);
        end else begin
            void'(pipe_q.pop_front());
            pipe_q.push_back({bus0.i_Sel1, bus0.i_Sel0, bus0.i_Auto,
                              bus0.i_Data3, bus0.i_Data2, bus0.i_Data1, bus0.i_Data0});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        check("d0_valid",  32'(bus0.o_Sample_Valid), 32'(m_valid[0]));
        check("d0_sel",    32'(bus0.o_Sel),          32'(m_sel[0]));
        check("d0_data",   32'(bus0.o_Data),         32'(m_data[0]));
        check("d0_change", 32'(bus0.o_Change),       32'(m_change[0]));
        check("d0_snap",   32'(bus0.o_Snapshot),     32'(m_snap[0]));
        check("d1_valid",  32'(bus1.o_Sample_Valid), 32'(m_valid[1]));
        check("d1_sel",    32'(bus1.o_Sel),          32'(m_sel[1]));
        check("d1_data",   32'(bus1.o_Data),         32'(m_data[1]));
        check("d1_change", 32'(bus1.o_Change),       32'(m_change[1]));
        check("d1_snap",   32'(bus1.o_Snapshot),     32'(m_snap[1]));
    endtask

    task automatic step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic set_data(input logic [3:0] v);
        bus0.i_Data0 = v[0]; bus0.i_Data1 = v[1];
        bus0.i_Data2 = v[2]; bus0.i_Data3 = v[3];
    endtask

    task automatic set_sel(input logic [1:0] v);
        bus0.i_Sel0 = v[0]; bus0.i_Sel1 = v[1];
    endtask

    // Steps until the LIMIT=3 build strobes (bounded), then checks fixed values.
    task automatic expect_strobe(input string tag, input logic [1:0] sel,
                                 input logic data, input logic change, output int waited);
        logic found = 1'b0;
        waited = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            step();
            waited++;
            if (bus0.o_Sample_Valid === 1'b1) found = 1'b1;
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
        if (found) begin
            check({tag, "_sel"},    32'(bus0.o_Sel),    32'(sel));
            check({tag, "_data"},   32'(bus0.o_Data),   32'(data));
            check({tag, "_change"}, 32'(bus0.o_Change), 32'(change));
        end
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        set_data(4'b0101);
        bus0.i_Auto = 1'b1;
        set_sel(2'd0);
        @(negedge clk);
        @(negedge clk);
        compare_model();
        check("rst_sel",   32'(bus0.o_Sel),          32'd3);
        check("rst_snap",  32'(bus0.o_Snapshot),     32'd0);
        check("rst_valid", 32'(bus0.o_Sample_Valid), 32'd0);
        check("rst_data",  32'(bus0.o_Data),         32'd0);
        rst_n = 1'b1;

        // First auto round: 0101 on data3..0
        expect_strobe("r1s0", 2'd0, 1'b1, 1'b1, w);
        check("r1_first_latency", 32'(w), 32'd4);
        expect_strobe("r1s1", 2'd1, 1'b0, 1'b0, w);
        check("r1_period", 32'(w), 32'd4);
        expect_strobe("r1s2", 2'd2, 1'b1, 1'b1, w);
        expect_strobe("r1s3", 2'd3, 1'b0, 1'b0, w);
        check("r1_snap", 32'(bus0.o_Snapshot), 32'b0101);

        // Second round, inputs unchanged: no change flags
        expect_strobe("r2s0", 2'd0, 1'b1, 1'b0, w);
        expect_strobe("r2s1", 2'd1, 1'b0, 1'b0, w);
        expect_strobe("r2s2", 2'd2, 1'b1, 1'b0, w);
        expect_strobe("r2s3", 2'd3, 1'b0, 1'b0, w);

        // Manual select 2, data2 low, then raised mid-period
        bus0.i_Auto = 1'b0;
        set_sel(2'd2);
        set_data(4'b0001);
        for (int i = 0; i < 12; i++) step();
        expect_strobe("m_settle", 2'd2, 1'b0, 1'b0, w);
        set_data(4'b0101);
        expect_strobe("m_rise", 2'd2, 1'b1, 1'b1, w);
        expect_strobe("m_hold", 2'd2, 1'b1, 1'b0, w);

        // Back to auto from sel 2: continues at 3, then 0
        bus0.i_Auto = 1'b1;
        set_sel(2'd1);
        expect_strobe("a_s3", 2'd3, 1'b0, 1'b0, w);
        expect_strobe("a_s0", 2'd0, 1'b1, 1'b0, w);

        // LIMIT=0 build strobes every cycle in steady auto mode
        for (int i = 0; i < 4; i++) begin
            step();
            check("lim0_valid", 32'(bus1.o_Sample_Valid), 32'd1);
        end

        // One-cycle reset mid-period
        step();
        step();
        rst_n = 1'b0;
        step();
        check("mr_sel",   32'(bus0.o_Sel),          32'd3);
        check("mr_snap",  32'(bus0.o_Snapshot),     32'd0);
        check("mr_valid", 32'(bus0.o_Sample_Valid), 32'd0);
        check("mr_valid1", 32'(bus1.o_Sample_Valid), 32'd0);
        rst_n = 1'b1;
        expect_strobe("mr_first", 2'd0, 1'b1, 1'b1, w);
        check("mr_latency", 32'(w), 32'd4);

        // Random phase: model checks every cycle
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) set_data(4'($urandom));
            if ($urandom_range(0, 15) == 0) bus0.i_Auto = 1'($urandom);
            if ($urandom_range(0, 2) == 0) set_sel(2'($urandom));
            rst_n = ($urandom_range(0, 60) != 0);
            step();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
